vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch
  H_SYNC, 96, horizontal sync width
  H_BP, 48, horizontal back porch
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch
  V_SYNC, 2, vertical sync width
  V_BP, 33, vertical back porch
  CLK_DIV, 2, system clocks per pixel (>=1)
  SYNC_POL, 0, sync active level (0 = active-low)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  system clock, rising edge
  rst  in  1  asynchronous, active-high reset
  pix_en  out  1  one-clk pixel strobe, once per CLK_DIV clocks
  hsync  out  1  horizontal sync, SYNC_POL when asserted
  vsync  out  1  vertical sync, SYNC_POL when asserted
  video_on  out  1  high inside the active area
  pix_x  out  10  current column, 0..H_TOTAL-1
  pix_y  out  10  current line, 0..V_TOTAL-1
  tile_col  out  7  pix_x[9:3], maze tile column
  tile_row  out  6  pix_y[8:3], maze tile row
  tile_px  out  3  pix_x[2:0], pixel within tile
  tile_py  out  3  pix_y[2:0], line within tile
  frame_start  out  1  one-clk pulse at pixel (0,0)
REQ-003 One clock (clk) SHALL be used; reset SHALL be asynchronous, active-high (rst).

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-005 Divider counts 0..CLK_DIV-1, wrapping; pix_en SHALL be high exactly on clocks where divider = CLK_DIV-1; with CLK_DIV=1 pix_en is constantly high after reset.
REQ-006 Horizontal counter SHALL advance only on pix_en; at H_TOTAL-1 it wraps to 0.
REQ-007 Vertical counter SHALL advance only on pix_en coinciding with horizontal wrap; at V_TOTAL-1 it wraps to 0 (both counters wrap on the same clock at frame end).
REQ-008 hsync asserted iff h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); otherwise !SYNC_POL.
REQ-009 vsync asserted iff v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for whole lines.
REQ-010 video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
REQ-011 All outputs except pix_en SHALL be registered and mutually aligned: each reflects the counter pair of the same pixel; they change only on the clock after pix_en and hold steady for CLK_DIV clocks.
REQ-012 tile_* SHALL be bit slices of the registered pix_x/pix_y; outside the active area they are don't-care for consumers but SHALL still equal those slices.
REQ-013 frame_start SHALL pulse for exactly one clk when registered pix_x=0 and pix_y=0 first appear, once per frame.
REQ-014 No counter SHALL exceed its TOTAL-1; all arithmetic unsigned, 10-bit.

Reset
REQ-015 While rst=1: divider=0, h=0, v=0, pix_x=0, pix_y=0, tile_*=0, video_on=0, hsync=vsync=!SYNC_POL, frame_start=0, pix_en=0.
REQ-016 Reset asserted mid-line/mid-frame SHALL take effect immediately (asynchronous) and discard position; after release, first pix_en occurs CLK_DIV clocks later and the first displayed pixel is (0,0) with frame_start pulsing.

Verification
REQ-017 Release rst, CLK_DIV=2 -> pix_en every 2nd clk; first outputs pix_x=0,pix_y=0,video_on=1,frame_start=1 one clk after first pix_en.
REQ-018 Run one line -> video_on high for 640 pixels; hsync low for exactly 96 pixels starting at pix_x=656; pix_x wraps 799->0 and pix_y increments.
REQ-019 Run full frame -> vsync low on lines 490-491 only (2x800 pixels); pix_y wraps 524->0; frame_start pulses exactly once per 420000 pixels.
REQ-020 Assert rst at pix_x=300,pix_y=200 for 3 clks -> outputs at reset values within the same cycle; restart at (0,0) per REQ-016.
REQ-021 CLK_DIV=1, SYNC_POL=1 -> pix_en always high after reset; hsync/vsync active-high with the same windows as REQ-018/019.
REQ-022 Check tile_col=pix_x>>3, tile_row=pix_y>>3 at pixel (639,479) -> 79, 59, tile_px=7, tile_py=7.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle driven by vga_timing_gen toward a pixel/tile renderer.
interface vga_timing_gen_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [6:0] tile_col;
  logic [5:0] tile_row;
  logic [2:0] tile_px;
  logic [2:0] tile_py;
  logic       frame_start;

  modport master (
    output pix_en, hsync, vsync, video_on, pix_x, pix_y,
           tile_col, tile_row, tile_px, tile_py, frame_start
  );

  modport slave (
    input  pix_en, hsync, vsync, video_on, pix_x, pix_y,
           tile_col, tile_row, tile_px, tile_py, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a clock divider produces the pixel strobe.
// Horizontal and vertical counters step on that strobe.
// Sync, blanking, position and tile coordinates are registered from the counter pair.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga_o
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  logic [9:0]       pix_x_q;
  logic [9:0]       pix_y_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             video_on_q;
  logic             frame_start_q;

  // Next-state for divider and raster counters; counters only move on the pixel strobe.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    tick   = (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    div_d  = tick ? '0 : div_q + DIV_ONE;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end
    end
  end

  // Divider and raster counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Registered outputs: on each strobe capture the decode of the pixel being left behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (tick) begin
        pix_x_q    <= h_q;
        pix_y_q    <= v_q;
        video_on_q <= (h_q < H_ACT) && (v_q < V_ACT);
        hsync_q    <= ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_q    <= ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      end
      frame_start_q <= tick && (h_q == '0) && (v_q == '0);
    end
  end

  // The strobe is masked by reset so CLK_DIV=1 still reads low while held in reset.
  assign vga_o.pix_en      = tick & ~rst;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.video_on    = video_on_q;
  assign vga_o.pix_x       = pix_x_q;
  assign vga_o.pix_y       = pix_y_q;
  assign vga_o.tile_col    = pix_x_q[9:3];
  assign vga_o.tile_row    = pix_y_q[8:3];
  assign vga_o.tile_px     = pix_x_q[2:0];
  assign vga_o.tile_py     = pix_y_q[2:0];
  assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen.
// Three instances: a scaled mode with CLK_DIV=2, the default 640x480 mode,
// and a scaled mode with CLK_DIV=1 and active-high syncs.
// Expected outputs come from a pixel-index model: clocks since release -> pixel number -> (x, y).
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int div; bit pol;
  } cfg_t;

  typedef struct packed {
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [6:0] tile_col;
    logic [5:0] tile_row;
    logic [2:0] tile_px;
    logic [2:0] tile_py;
    logic       frame_start;
  } vout_t;

  localparam cfg_t CA = '{ha: 40, hf: 4, hs: 6, hb: 5, va: 24, vf: 2, vs: 2, vb: 3, div: 2, pol: 1'b0};
  localparam cfg_t CB = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, div: 2, pol: 1'b0};
  localparam cfg_t CC = '{ha: 40, hf: 4, hs: 6, hb: 5, va: 24, vf: 2, vs: 2, vb: 3, div: 1, pol: 1'b1};

  logic clk = 1'b0;
  logic rst;
  int   n;
  int   total;
  int   bad;
  bit   acc_on;
  int   a_fs, a_vs, a_hs, a_vo;
  int   c_fs, c_vs, c_hs;
  int   b_hs, b_vo;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(
    .H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
    .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb),
    .CLK_DIV(CA.div), .SYNC_POL(CA.pol)
  ) dut_a (.clk(clk), .rst(rst), .vga_o(if_a));

  vga_timing_gen dut_b (.clk(clk), .rst(rst), .vga_o(if_b));

  vga_timing_gen #(
    .H_ACTIVE(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
    .V_ACTIVE(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb),
    .CLK_DIV(CC.div), .SYNC_POL(CC.pol)
  ) dut_c (.clk(clk), .rst(rst), .vga_o(if_c));

  vout_t obs_a, obs_b, obs_c;
  assign obs_a = {if_a.pix_en, if_a.hsync, if_a.vsync, if_a.video_on, if_a.pix_x, if_a.pix_y,
                  if_a.tile_col, if_a.tile_row, if_a.tile_px, if_a.tile_py, if_a.frame_start};
  assign obs_b = {if_b.pix_en, if_b.hsync, if_b.vsync, if_b.video_on, if_b.pix_x, if_b.pix_y,
                  if_b.tile_col, if_b.tile_row, if_b.tile_px, if_b.tile_py, if_b.frame_start};
  assign obs_c = {if_c.pix_en, if_c.hsync, if_c.vsync, if_c.video_on, if_c.pix_x, if_c.pix_y,
                  if_c.tile_col, if_c.tile_row, if_c.tile_px, if_c.tile_py, if_c.frame_start};

  // Outputs expected after the n-th rising edge since reset release.
  function automatic vout_t model(cfg_t c, bit in_rst, int clocks);
    vout_t e;
    int ht, vt, m, x, y;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e.pix_en = 1'b0; e.hsync = ~c.pol; e.vsync = ~c.pol; e.video_on = 1'b0;
    e.pix_x = '0; e.pix_y = '0; e.tile_col = '0; e.tile_row = '0;
    e.tile_px = '0; e.tile_py = '0; e.frame_start = 1'b0;
    if (!in_rst) begin
      e.pix_en = (((clocks + 1) % c.div) == 0);
      m = clocks / c.div - 1;
      if (m >= 0) begin
        x = m % ht;
        y = (m / ht) % vt;
        e.pix_x       = 10'(x);
        e.pix_y       = 10'(y);
        e.video_on    = (x < c.ha) && (y < c.va);
        e.hsync       = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
        e.vsync       = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
        e.tile_col    = 7'(x / 8);
        e.tile_row    = 6'((y / 8) % 64);
        e.tile_px     = 3'(x % 8);
        e.tile_py     = 3'(y % 8);
        e.frame_start = ((clocks % c.div) == 0) && (x == 0) && (y == 0);
      end
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (n=%0d)", tag, observed, expected, n);
    end
  endtask

  task automatic check_dut(string nm, vout_t o, vout_t e);
    check({nm, ".pix_en"},      32'(o.pix_en),      32'(e.pix_en));
    check({nm, ".hsync"},       32'(o.hsync),       32'(e.hsync));
    check({nm, ".vsync"},       32'(o.vsync),       32'(e.vsync));
    check({nm, ".video_on"},    32'(o.video_on),    32'(e.video_on));
    check({nm, ".pix_x"},       32'(o.pix_x),       32'(e.pix_x));
    check({nm, ".pix_y"},       32'(o.pix_y),       32'(e.pix_y));
    check({nm, ".tile_col"},    32'(o.tile_col),    32'(e.tile_col));
    check({nm, ".tile_row"},    32'(o.tile_row),    32'(e.tile_row));
    check({nm, ".tile_px"},     32'(o.tile_px),     32'(e.tile_px));
    check({nm, ".tile_py"},     32'(o.tile_py),     32'(e.tile_py));
    check({nm, ".frame_start"}, 32'(o.frame_start), 32'(e.frame_start));
  endtask

  task automatic check_all();
    check_dut("a", obs_a, model(CA, rst, n));
    check_dut("b", obs_b, model(CB, rst, n));
    check_dut("c", obs_c, model(CC, rst, n));
  endtask

  // Per-pixel tallies, taken on the first clock each new pixel is shown.
  task automatic accumulate();
    if (acc_on && !rst && n > 0) begin
      if (n % CA.div == 0) begin
        if (obs_a.frame_start === 1'b1) a_fs++;
        if (obs_a.vsync === CA.pol) a_vs++;
        if (obs_a.hsync === CA.pol) a_hs++;
        if (obs_a.video_on === 1'b1) a_vo++;
      end
      if (n % CC.div == 0) begin
        if (obs_c.frame_start === 1'b1) c_fs++;
        if (obs_c.vsync === CC.pol) c_vs++;
        if (obs_c.hsync === CC.pol) c_hs++;
      end
      if (n % CB.div == 0 && n <= CB.div * 800) begin
        if (obs_b.hsync === CB.pol) b_hs++;
        if (obs_b.video_on === 1'b1) b_vo++;
      end
    end
  endtask

  task automatic step(int clocks);
    for (int i = 0; i < clocks; i++) begin
      @(posedge clk);
      if (!rst) n++;
      @(negedge clk);
      check_all();
      accumulate();
    end
  endtask

  // Called at a falling edge: raise reset mid-cycle, hold it, then drop it mid-cycle.
  task automatic reset_pulse(int hold);
    #($urandom_range(1, 3));
    rst = 1'b1;
    n   = 0;
    #1;
    check_all();
    step(hold);
    #($urandom_range(1, 3));
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; n = 0; total = 0; bad = 0; acc_on = 1'b0;
    a_fs = 0; a_vs = 0; a_hs = 0; a_vo = 0;
    c_fs = 0; c_vs = 0; c_hs = 0; b_hs = 0; b_vo = 0;

    #1;
    check_all();
    step(3);

    // Release and watch the first pixel appear.
    #2 rst = 1'b0;
    acc_on = 1'b1;
    step(1);
    check("a.first_pix_en", 32'(if_a.pix_en), 32'd1);
    check("c.pix_en_high", 32'(if_c.pix_en), 32'd1);
    step(1);
    check("a.first_x", 32'(if_a.pix_x), 32'd0);
    check("a.first_y", 32'(if_a.pix_y), 32'd0);
    check("a.first_video_on", 32'(if_a.video_on), 32'd1);
    check("a.first_frame_start", 32'(if_a.frame_start), 32'd1);

    // One full scaled frame for A (two for C, first line and a bit for B).
    step(CA.div * 55 * 31 - n);
    acc_on = 1'b0;
    check("a.frame_start_count", 32'(a_fs), 32'd1);
    check("a.vsync_pixels", 32'(a_vs), 32'(CA.vs * 55));
    check("a.hsync_pixels", 32'(a_hs), 32'(CA.hs * 31));
    check("a.video_pixels", 32'(a_vo), 32'(CA.ha * CA.va));
    check("c.frame_start_count", 32'(c_fs), 32'd2);
    check("c.vsync_pixels", 32'(c_vs), 32'(2 * CC.vs * 55));
    check("c.hsync_pixels", 32'(c_hs), 32'(2 * CC.hs * 31));
    check("b.hsync_pixels_line0", 32'(b_hs), 32'd96);
    check("b.video_pixels_line0", 32'(b_vo), 32'd640);

    // Reset mid-frame with A at (30,20) of its second frame.
    step(CA.div * (55 * 31 + 20 * 55 + 30 + 1) - n);
    check("a.pre_reset_x", 32'(if_a.pix_x), 32'd30);
    check("a.pre_reset_y", 32'(if_a.pix_y), 32'd20);
    reset_pulse(3);
    step(2);
    check("a.restart_frame_start", 32'(if_a.frame_start), 32'd1);

    // Last active pixel of the scaled mode: (39,23).
    step(CA.div * (23 * 55 + 39 + 1) - n);
    check("a.tile_col", 32'(if_a.tile_col), 32'd4);
    check("a.tile_row", 32'(if_a.tile_row), 32'd2);
    check("a.tile_px", 32'(if_a.tile_px), 32'd7);
    check("a.tile_py", 32'(if_a.tile_py), 32'd7);

    // Randomized run lengths and reset pulses.
    for (int k = 0; k < 4; k++) begin
      step($urandom_range(20, 1500));
      reset_pulse($urandom_range(1, 4));
    end
    step(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
